// File: rtl/inst_mem_arb_pkg.sv
// Shared types and defaults for the two-master instruction RAM arbiter.
package inst_mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 12;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_HOLD_MAX = 4;
  localparam int unsigned HOLD_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  function automatic logic [HOLD_CNT_W-1:0] sat_inc(input logic [HOLD_CNT_W-1:0] v);
    return (v == '1) ? v : HOLD_CNT_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// Avalon-MM bundle: fetch master (m0), loader master (m1) and the RAM port.
interface inst_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [BE_W-1:0]   m1_byteenable;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  // Arbiter view.
  modport slave (
    input  m0_address, m0_read,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  // Environment view: both masters plus the RAM.
  modport master (
    output m0_address, m0_read,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/inst_mem_arb_rr.sv
// Grant/hold logic: one grant per cycle, bounded hold, zero-bubble handover.
module inst_mem_arb_rr
  import inst_mem_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  arb_state_e            state, nxt_state;
  logic [HOLD_CNT_W-1:0] hold_cnt, nxt_hold;
  logic                  last_gnt;
  logic                  r0, r1, pick1, take_idle;

  // No grants are issued while reset is held.
  assign r0    = req0 & reset_n;
  assign r1    = req1 & reset_n;
  assign pick1 = (r0 && r1) ? ~last_gnt : r1;

  always_comb begin
    nxt_state = state;
    nxt_hold  = hold_cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    take_idle = 1'b0;
    unique case (state)
      OWN0: begin
        if (r0) begin
          if (!r1 || hold_cnt < HOLD_CNT_W'(HOLD_MAX)) begin
            gnt0     = 1'b1;
            nxt_hold = sat_inc(hold_cnt);
          end else begin
            gnt1      = 1'b1;
            nxt_state = OWN1;
            nxt_hold  = HOLD_CNT_W'(1);
          end
        end else begin
          take_idle = 1'b1;
        end
      end
      OWN1: begin
        if (r1) begin
          if (!r0 || hold_cnt < HOLD_CNT_W'(HOLD_MAX)) begin
            gnt1     = 1'b1;
            nxt_hold = sat_inc(hold_cnt);
          end else begin
            gnt0      = 1'b1;
            nxt_state = OWN0;
            nxt_hold  = HOLD_CNT_W'(1);
          end
        end else begin
          take_idle = 1'b1;
        end
      end
      default: take_idle = 1'b1;
    endcase
    // Owner dropped its request: arbitrate as from IDLE in the same cycle.
    if (take_idle) begin
      if (r0 || r1) begin
        gnt0      = ~pick1;
        gnt1      = pick1;
        nxt_state = pick1 ? OWN1 : OWN0;
        nxt_hold  = HOLD_CNT_W'(1);
      end else begin
        nxt_state = IDLE;
        nxt_hold  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_hold;
      if (gnt0)      last_gnt <= 1'b0;
      else if (gnt1) last_gnt <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Two-master arbiter for the single-port instruction RAM (1-cycle read latency).
// Optional stall counters enabled by defining INST_MEM_ARB_PERF_EN.
module inst_mem_arbiter
  import inst_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic               clk,
  input  logic               reset_n,
  inst_mem_arbiter_if.slave  bus
`ifdef INST_MEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_m0_stall,
  output logic [31:0]        perf_m1_stall
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic              req0, req1, gnt0, gnt1, m1_rd_only;
  logic [1:0]        rd_owner;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign req0       = bus.m0_read;
  assign req1       = bus.m1_read | bus.m1_write;
  assign m1_rd_only = bus.m1_read & ~bus.m1_write;

  inst_mem_arb_rr #(.HOLD_MAX(HOLD_MAX)) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  // Request mux toward the RAM; fetches always use full-word enables.
  assign addr_sel           = gnt1 ? bus.m1_address : bus.m0_address;
  assign wdata_sel          = bus.m1_writedata;
  assign bus.mem_address    = addr_sel;
  assign bus.mem_writedata  = wdata_sel;
  assign bus.mem_byteenable = gnt1 ? bus.m1_byteenable : {BE_W{1'b1}};
  assign bus.mem_chipselect = gnt0 | gnt1;
  assign bus.mem_write      = gnt1 & bus.m1_write;
  assign bus.mem_clken      = reset_n;

  assign bus.m0_waitrequest = ~gnt0;
  assign bus.m1_waitrequest = ~gnt1;

  // Return path: remember who issued the read accepted this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_owner <= 2'b00;
    else          rd_owner <= {gnt1 & m1_rd_only, gnt0};
  end

  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;
  assign bus.m0_readdatavalid = rd_owner[0];
  assign bus.m1_readdatavalid = rd_owner[1];

`ifdef INST_MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_m0_stall <= '0;
      perf_m1_stall <= '0;
    end else begin
      if (req0 && !gnt0) perf_m0_stall <= perf_m0_stall + 32'd1;
      if (req1 && !gnt1) perf_m1_stall <= perf_m1_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Scoreboard bench for inst_mem_arbiter with a behavioural 4096x32 RAM.
// Stall counter checks compile in when INST_MEM_ARB_PERF_EN is defined.
module tb_inst_mem_arbiter;

  localparam int WAIT_LIMIT = 20;

  typedef struct packed {
    logic [3:0]  gap;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } op_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m0_maxw = 0;
  int   m1_maxw = 0;

  op_t         m0_ops[$];
  op_t         m1_ops[$];
  exp_t        exp0_q[$];
  exp_t        exp1_q[$];
  string       chk_name[$];
  logic [31:0] chk_act[$];
  logic [31:0] chk_exp[$];
  logic [31:0] ram [4096];

  inst_mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

`ifdef INST_MEM_ARB_PERF_EN
  logic [31:0] perf_m0_stall, perf_m1_stall;
`endif

  inst_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .HOLD_MAX(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
`ifdef INST_MEM_ARB_PERF_EN
    .perf_m0_stall (perf_m0_stall),
    .perf_m1_stall (perf_m1_stall),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: image word i = 0xC0DE0000 | i, byte-enabled writes, 1-cycle read.
  initial for (int i = 0; i < 4096; i++) ram[i] = 32'hC0DE0000 | 32'(i);
  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        bus.mem_readdata <= ram[bus.mem_address];
      end
    end
  end

  task automatic post_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  // Monitor: evaluates posted checks and scores every readdatavalid.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    logic [31:0] a, x;
    while (chk_name.size() != 0) begin
      n = chk_name.pop_front();
      a = chk_act.pop_front();
      x = chk_exp.pop_front();
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
    end
    if (reset_n && bus.m0_readdatavalid) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL m0_unexpected_valid: got data %0h at cycle %0d, expected none", bus.m0_readdata, cyc);
      end else begin
        e = exp0_q.pop_front();
        if (bus.m0_readdata !== e.data || 32'(cyc) !== e.cyc) begin
          errors++;
          $display("FAIL m0_read: got %0h at cycle %0d expected %0h at cycle %0d",
                   bus.m0_readdata, cyc, e.data, e.cyc);
        end
      end
    end
    if (reset_n && bus.m1_readdatavalid) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL m1_unexpected_valid: got data %0h at cycle %0d, expected none", bus.m1_readdata, cyc);
      end else begin
        e = exp1_q.pop_front();
        if (bus.m1_readdata !== e.data || 32'(cyc) !== e.cyc) begin
          errors++;
          $display("FAIL m1_read: got %0h at cycle %0d expected %0h at cycle %0d",
                   bus.m1_readdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  function automatic op_t mk(input logic [3:0] gap, input logic rd, input logic wr,
                             input logic [11:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] exp);
    op_t o;
    o.gap = gap; o.rd = rd; o.wr = wr; o.addr = addr; o.be = be; o.wdata = wdata; o.exp = exp;
    return o;
  endfunction

  task automatic drive_m0();
    op_t op;
    int  w;
    m0_maxw = 0;
    while (m0_ops.size() != 0) begin
      op = m0_ops.pop_front();
      repeat (int'(op.gap)) begin @(posedge clk); #1; end
      bus.m0_read    = 1'b1;
      bus.m0_address = op.addr;
      w = 0;
      forever begin
        @(negedge clk);
        if (!bus.m0_waitrequest) break;
        w++;
        if (w > WAIT_LIMIT) break;
        @(posedge clk); #1;
      end
      if (w > m0_maxw) m0_maxw = w;
      if (w > WAIT_LIMIT) post_chk("m0_wait_timeout", 32'(w), 32'(WAIT_LIMIT));
      else                exp0_q.push_back('{op.exp, 32'(cyc + 1)});
      @(posedge clk); #1;
      bus.m0_read = 1'b0;
    end
    bus.m0_read = 1'b0;
  endtask

  task automatic drive_m1();
    op_t op;
    int  w;
    m1_maxw = 0;
    while (m1_ops.size() != 0) begin
      op = m1_ops.pop_front();
      repeat (int'(op.gap)) begin @(posedge clk); #1; end
      bus.m1_read       = op.rd;
      bus.m1_write      = op.wr;
      bus.m1_address    = op.addr;
      bus.m1_byteenable = op.be;
      bus.m1_writedata  = op.wdata;
      w = 0;
      forever begin
        @(negedge clk);
        if (!bus.m1_waitrequest) break;
        w++;
        if (w > WAIT_LIMIT) break;
        @(posedge clk); #1;
      end
      if (w > m1_maxw) m1_maxw = w;
      if (w > WAIT_LIMIT)  post_chk("m1_wait_timeout", 32'(w), 32'(WAIT_LIMIT));
      else if (!op.wr)     exp1_q.push_back('{op.exp, 32'(cyc + 1)});
      @(posedge clk); #1;
      bus.m1_read  = 1'b0;
      bus.m1_write = 1'b0;
    end
    bus.m1_read  = 1'b0;
    bus.m1_write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    bus.m0_read       = 1'b0;
    bus.m0_address    = '0;
    bus.m1_read       = 1'b0;
    bus.m1_write      = 1'b0;
    bus.m1_address    = '0;
    bus.m1_byteenable = '0;
    bus.m1_writedata  = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_and_drain(input string tag);
    fork
      drive_m0();
      drive_m1();
    join
    repeat (2) @(negedge clk);
    post_chk({tag, "_m0_pending"}, 32'(exp0_q.size()), 32'd0);
    post_chk({tag, "_m1_pending"}, 32'(exp1_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    post_chk({tag, "_m0_wait"},  32'(bus.m0_waitrequest), 32'd1);
    post_chk({tag, "_m1_wait"},  32'(bus.m1_waitrequest), 32'd1);
    post_chk({tag, "_m0_rdv"},   32'(bus.m0_readdatavalid), 32'd0);
    post_chk({tag, "_m1_rdv"},   32'(bus.m1_readdatavalid), 32'd0);
    post_chk({tag, "_cs"},       32'(bus.mem_chipselect), 32'd0);
    post_chk({tag, "_write"},    32'(bus.mem_write), 32'd0);
    post_chk({tag, "_clken"},    32'(bus.mem_clken), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with m0 requesting to confirm grants are held off.
    bus.m0_read = 1'b1;
    bus.m1_write = 1'b0; bus.m1_read = 1'b1;
    bus.m0_address = '0; bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_writedata = '0;
    @(negedge clk);
    check_reset_outputs("rst");

    // Back-to-back fetches, loader idle.
    do_reset();
    for (int i = 0; i < 4; i++) m0_ops.push_back(mk(4'd0, 1'b1, 1'b0, 12'(i), 4'hF, 32'h0, 32'hC0DE0000 | 32'(i)));
    run_and_drain("t1");
    post_chk("t1_m0_maxwait", 32'(m0_maxw), 32'd0);

    // Both continuous: 4/4 alternation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m0_ops.push_back(mk(4'd0, 1'b1, 1'b0, 12'h100 + 12'(i), 4'hF, 32'h0, 32'hC0DE0100 + 32'(i)));
      m1_ops.push_back(mk(4'd0, 1'b1, 1'b0, 12'h200 + 12'(i), 4'hF, 32'h0, 32'hC0DE0200 + 32'(i)));
    end
    run_and_drain("t2");
    post_chk("t2_m0_maxwait", 32'(m0_maxw), 32'd4);
    post_chk("t2_m1_maxwait", 32'(m1_maxw), 32'd4);

    // Partial write then immediate read-back.
    do_reset();
    m1_ops.push_back(mk(4'd0, 1'b0, 1'b1, 12'h010, 4'b0011, 32'hDEADBEEF, 32'h0));
    m0_ops.push_back(mk(4'd1, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0, 32'hC0DEBEEF));
    run_and_drain("t3");
    post_chk("t3_m0_maxwait", 32'(m0_maxw), 32'd0);
    post_chk("t3_m1_maxwait", 32'(m1_maxw), 32'd0);

    // Simultaneous first request: m0 wins, m1 waits one cycle.
    do_reset();
    m0_ops.push_back(mk(4'd0, 1'b1, 1'b0, 12'h020, 4'hF, 32'h0, 32'hC0DE0020));
    m1_ops.push_back(mk(4'd0, 1'b1, 1'b0, 12'h030, 4'hF, 32'h0, 32'hC0DE0030));
    run_and_drain("t4");
    post_chk("t4_m0_maxwait", 32'(m0_maxw), 32'd0);
    post_chk("t4_m1_maxwait", 32'(m1_maxw), 32'd1);

    // Loader stalled 4 + 3 cycles behind a continuous fetch stream.
    do_reset();
    for (int i = 0; i < 10; i++) m0_ops.push_back(mk(4'd0, 1'b1, 1'b0, 12'h300 + 12'(i), 4'hF, 32'h0, 32'hC0DE0300 + 32'(i)));
    m1_ops.push_back(mk(4'd0, 1'b1, 1'b0, 12'h3A0, 4'hF, 32'h0, 32'hC0DE03A0));
    m1_ops.push_back(mk(4'd1, 1'b1, 1'b0, 12'h3B0, 4'hF, 32'h0, 32'hC0DE03B0));
    run_and_drain("t6");
    post_chk("t6_m0_maxwait", 32'(m0_maxw), 32'd1);
    post_chk("t6_m1_maxwait", 32'(m1_maxw), 32'd4);
`ifdef INST_MEM_ARB_PERF_EN
    post_chk("t6_perf_m0", perf_m0_stall, 32'd2);
    post_chk("t6_perf_m1", perf_m1_stall, 32'd7);
`endif

    // Reset asserted right after an m1 read is accepted.
    do_reset();
    bus.m1_read = 1'b1; bus.m1_address = 12'h040;
    @(negedge clk);
    post_chk("t5_m1_accept", 32'(bus.m1_waitrequest), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.m1_read = 1'b0;
    bus.m0_read = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.m0_read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      post_chk("t5_m1_rdv_after", 32'(bus.m1_readdatavalid), 32'd0);
    end
    post_chk("t5_m1_pending", 32'(exp1_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
